// File: rtl/uart_tx_core_if.sv
// Byte handshake between a byte-producing controller (master) and uart_tx_core (slave).
interface uart_tx_core_if;
  logic [7:0] d_in;
  logic       tx_en;
  logic       start;
  logic       busy;
  logic       done;

  modport master (
    output d_in,
    output tx_en,
    input  start,
    input  busy,
    input  done
  );

  modport slave (
    input  d_in,
    input  tx_en,
    output start,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter with a gated, frame-aligned baud generator and registered outputs.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx_core #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_core_if.slave host,
  output logic          seri_out,
  output logic          baud_tick,
  output logic          tick_8x
);
  localparam int BIT_CYC = CLK_FREQ / BAUD;
  localparam int SUB_CYC = BIT_CYC / 8;
  localparam int BW      = $clog2(BIT_CYC);
  localparam int SW      = $clog2(SUB_CYC);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CYC - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(SUB_CYC - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_reg;
  logic [7:0]    shreg_reg;
  logic [2:0]    idx_reg;
  logic [BW-1:0] bit_cnt_reg;
  logic [SW-1:0] sub_cnt_reg;
  logic          start_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          seri_reg;
  logic          baud_tick_reg;
  logic          tick_8x_reg;
`ifdef UART_TX_PARITY_EN
  logic          parity_reg;
`endif

  logic [BW-1:0] bit_cnt_next;
  logic [SW-1:0] sub_cnt_next;
  logic          frame_end;

  always_comb begin
    bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + BW'(1);
    sub_cnt_next = (sub_cnt_reg == SUB_LAST) ? '0 : sub_cnt_reg + SW'(1);
    frame_end    = (state_reg == STOP) && baud_tick_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      shreg_reg     <= '0;
      idx_reg       <= '0;
      bit_cnt_reg   <= '0;
      sub_cnt_reg   <= '0;
      start_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      seri_reg      <= 1'b1;
      baud_tick_reg <= 1'b0;
      tick_8x_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg    <= 1'b0;
`endif
    end else begin
      start_reg <= 1'b0;
      done_reg  <= 1'b0;

      // Ticks are looked ahead one cycle so they line up with the counter value they flag.
      if (busy_reg && !frame_end) begin
        bit_cnt_reg   <= bit_cnt_next;
        sub_cnt_reg   <= sub_cnt_next;
        baud_tick_reg <= (bit_cnt_next == BIT_LAST);
        tick_8x_reg   <= (sub_cnt_next == SUB_LAST);
      end else begin
        bit_cnt_reg   <= '0;
        sub_cnt_reg   <= '0;
        baud_tick_reg <= 1'b0;
        tick_8x_reg   <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          seri_reg <= 1'b1;
          if (host.tx_en) begin
            shreg_reg <= host.d_in;
`ifdef UART_TX_PARITY_EN
            parity_reg <= ^host.d_in;
`endif
            start_reg <= 1'b1;
            busy_reg  <= 1'b1;
            seri_reg  <= 1'b0;
            state_reg <= START;
          end
        end
        START: begin
          if (baud_tick_reg) begin
            seri_reg  <= shreg_reg[0];
            idx_reg   <= '0;
            state_reg <= DATA;
          end
        end
        DATA: begin
          if (baud_tick_reg) begin
            shreg_reg <= {1'b0, shreg_reg[7:1]};
            if (idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              seri_reg  <= parity_reg;
              state_reg <= PARITY;
`else
              seri_reg  <= 1'b1;
              state_reg <= STOP;
`endif
            end else begin
              idx_reg  <= idx_reg + 3'd1;
              seri_reg <= shreg_reg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_tick_reg) begin
            seri_reg  <= 1'b1;
            state_reg <= STOP;
          end
        end
`endif
        STOP: begin
          seri_reg <= 1'b1;
          if (baud_tick_reg) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          seri_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign host.start = start_reg;
  assign host.busy  = busy_reg;
  assign host.done  = done_reg;
  assign seri_out   = seri_reg;
  assign baud_tick  = baud_tick_reg;
  assign tick_8x    = tick_8x_reg;
endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: per-cycle reference model, table of frames, corner sequences, random traffic.
module tb_uart_tx_core;
  localparam int CLK_FREQ = 3_200_000;
  localparam int BAUD     = 100_000;
  localparam int BC       = CLK_FREQ / BAUD;
  localparam int SUB      = BC / 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic seri_out, baud_tick, tick_8x;

  uart_tx_core_if host();

  uart_tx_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host),
    .seri_out  (seri_out),
    .baud_tick (baud_tick),
    .tick_8x   (tick_8x)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  // Expected wire sequence: start, 8 data bits LSB first, optional even parity, stop.
  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] d);
    logic [NBITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    f[NBITS-1] = 1'b1;
    return f;
  endfunction

  // Reference model: time elapsed since the accepted request drives every output.
  int pos = -1;
  logic [NBITS-1:0] mbits = '1;
  logic m_start = 1'b0;
  logic m_done = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst);
    m_start = 1'b0;
    m_done  = 1'b0;
    if (!rst) begin
      pos = -1;
    end else if (pos >= 0) begin
      pos++;
      if (pos == FRAME) begin
        pos = -1;
        m_done = 1'b1;
      end
    end else if (host.tx_en === 1'b1) begin
      pos = 0;
      m_start = 1'b1;
      mbits = frame_bits(host.d_in);
    end
  end

  initial forever begin
    logic [5:0] exp_v;
    logic [5:0] act_v;
    @(negedge clk);
    if (pos >= 0)
      exp_v = {mbits[pos / BC], 1'b1, m_start, m_done,
               1'(pos % BC == BC - 1), 1'(pos % SUB == SUB - 1)};
    else
      exp_v = {1'b1, 1'b0, m_start, m_done, 1'b0, 1'b0};
    act_v = {seri_out, host.busy, host.start, host.done, baud_tick, tick_8x};
    check("cycle{seri,busy,start,done,baud,8x}", 32'(act_v), 32'(exp_v));
    if (host.start === 1'b1) start_cnt++;
    if (host.done === 1'b1) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b);
    host.d_in  = b;
    host.tx_en = 1'b1;
    @(negedge clk);
    host.tx_en = 1'b0;
  endtask

  // Bit-period sampler; done_at = cycles from first low line cycle to done, -1 on timeout.
  task automatic rx_frame(output logic [NBITS-1:0] line, output int done_at);
    int w;
    line = '1;
    done_at = -1;
    w = 0;
    while (seri_out !== 1'b0 && w < 4 * BC) begin
      @(negedge clk);
      w++;
    end
    if (seri_out !== 1'b0) return;
    for (int c = 0; c <= FRAME + 4; c++) begin
      if (c % BC == BC / 2 && c / BC < NBITS) line[c / BC] = seri_out;
      if (host.done === 1'b1 && done_at < 0) done_at = c;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic [8:0] head;
    logic       par;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];
  logic [NBITS-1:0] line;
  int dat, s0, d0, gap, w;
  logic [7:0] b;

  initial begin
    vecs[0] = '{8'h55, 9'b010101010, 1'b0};
    vecs[1] = '{8'h00, 9'b000000000, 1'b0};
    vecs[2] = '{8'hFF, 9'b111111110, 1'b0};
    vecs[3] = '{8'hA5, 9'b101001010, 1'b0};
    vecs[4] = '{8'h3C, 9'b001111000, 1'b0};
    vecs[5] = '{8'h07, 9'b000001110, 1'b1};
    vecs[6] = '{8'h80, 9'b100000000, 1'b1};
    vecs[7] = '{8'h01, 9'b000000010, 1'b1};

    host.d_in  = 8'h00;
    host.tx_en = 1'b0;

    // Reset held for several cycles with a request pending: must stay idle.
    host.tx_en = 1'b1;
    repeat (8) @(negedge clk);
    check("reset_seri", 32'(seri_out), 32'd1);
    check("reset_busy", 32'(host.busy), 32'd0);
    check("reset_start", 32'(host.start), 32'd0);
    host.tx_en = 1'b0;
    #2 rst = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_after_reset", 32'(seri_out), 32'd1);

    // Table of frames with gaps.
    for (int i = 0; i < NV; i++) begin
      s0 = start_cnt;
      d0 = done_cnt;
      send(vecs[i].d);
      rx_frame(line, dat);
      check($sformatf("vec%0d_head", i), 32'(line[8:0]), 32'(vecs[i].head));
`ifdef UART_TX_PARITY_EN
      check($sformatf("vec%0d_parity", i), 32'(line[9]), 32'(vecs[i].par));
`endif
      check($sformatf("vec%0d_stop", i), 32'(line[NBITS-1]), 32'd1);
      check($sformatf("vec%0d_done_cycle", i), 32'(dat), 32'(FRAME));
      check($sformatf("vec%0d_start_pulses", i), 32'(start_cnt - s0), 32'd1);
      check($sformatf("vec%0d_done_pulses", i), 32'(done_cnt - d0), 32'd1);
      repeat (BC / 2) @(negedge clk);
    end

    // Request and new data while busy are ignored.
    s0 = start_cnt;
    d0 = done_cnt;
    send(8'h3C);
    fork
      rx_frame(line, dat);
      begin
        repeat (2 * BC + 7) @(negedge clk);
        host.d_in  = 8'hFF;
        host.tx_en = 1'b1;
        repeat (3) @(negedge clk);
        host.tx_en = 1'b0;
      end
    join
    check("busy_req_head", 32'(line[8:0]), 32'(9'b001111000));
    check("busy_req_done_cycle", 32'(dat), 32'(FRAME));
    check("busy_req_start_pulses", 32'(start_cnt - s0), 32'd1);
    check("busy_req_done_pulses", 32'(done_cnt - d0), 32'd1);
    repeat (BC) @(negedge clk);

    // Reset during data bit 3 aborts the frame.
    send(8'hA5);
    repeat (4 * BC + BC / 2) @(negedge clk);
    check("pre_reset_bit3", 32'(seri_out), 32'd0);
    d0 = done_cnt;
    #2 rst = 1'b0;
    #1;
    check("mid_reset_seri", 32'(seri_out), 32'd1);
    check("mid_reset_busy", 32'(host.busy), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    repeat (FRAME) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    send(8'h3C);
    rx_frame(line, dat);
    check("post_reset_head", 32'(line[8:0]), 32'(9'b001111000));
    check("post_reset_done_cycle", 32'(dat), 32'(FRAME));
    repeat (BC) @(negedge clk);

    // Held request: back-to-back frames, second one picks up the new byte.
    host.d_in  = 8'h81;
    host.tx_en = 1'b1;
    w = 0;
    while (host.start !== 1'b1 && w < 8) begin @(negedge clk); w++; end
    check("b2b_first_start_seen", 32'(host.start), 32'd1);
    host.d_in = 8'h42;
    @(negedge clk);
    w = 1;
    while (host.start !== 1'b1 && w < FRAME + 8) begin @(negedge clk); w++; end
    check("b2b_start_spacing", 32'(w), 32'(FRAME + 1));
    check("b2b_line_falls", 32'(seri_out), 32'd0);
    host.tx_en = 1'b0;
    repeat (FRAME + 2 * BC) @(negedge clk);
    check("b2b_idle_after", 32'(host.busy), 32'd0);

    // Random traffic with random ignored requests during each frame.
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      gap = $urandom_range(0, 2 * BC);
      repeat (gap) @(negedge clk);
      send(b);
      fork
        rx_frame(line, dat);
        begin
          repeat ($urandom_range(1, FRAME - 10)) @(negedge clk);
          host.d_in  = 8'($urandom);
          host.tx_en = 1'b1;
          @(negedge clk);
          host.tx_en = 1'b0;
        end
      join
      check($sformatf("rand%0d_data", k), 32'(line[8:1]), 32'(b));
`ifdef UART_TX_PARITY_EN
      check($sformatf("rand%0d_parity", k), 32'(line[9]), 32'(^b));
`endif
      check($sformatf("rand%0d_done_cycle", k), 32'(dat), 32'(FRAME));
    end
    repeat (BC) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
